fwd_hazard_ctrl: RTL and testbench

Parametrised operand-forwarding and RAW-hazard controller for the rv32 pipeline. It keeps an internal shadow pipeline of in-flight destination tags across NSTAGE post-decode stages, and forwards the youngest ready producer result to each of NSRC decode-stage source operands. It raises a load-use stall when a producer's data is not yet available, and keeps a stall-cycle performance counter. It sits beside the decode stage and drives the operand bypass muxes and the front-end stall.

---
 rtl/fwd_hazard_ctrl.sv | 108 ++++++++++
 tb/tb_fwd_hazard_ctrl.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/fwd_hazard_ctrl.sv
// fwd_hazard_ctrl
// Operand-forwarding and RAW-hazard controller for the rv32 decode stage.
// A shadow pipeline tracks the destination tag of every instruction in the
// NSTAGE post-decode stages (0 = EX, 1 = MEM/ACC, 2 = WB). Each decode source
// operand is compared against that shadow pipeline and the youngest matching
// producer either forwards its stage_result slice or raises a load-use stall.
//
// Ports
//   clk, rst       clock, asynchronous active-high reset
//   issue_*        decode instruction: valid, rd, writes-rd, is-load
//   src_addr/used  NSRC source register addresses (5 bits each) and use flags
//   stage_result   NSTAGE result words, slice i = stage i
//   flush          redirect: kill decode instruction and current stage-0 entry
//   stall          hold fetch/decode
//   fwd_hit/data   per-operand bypass select and bypass value
//   stall_cycles   saturating count of stalled cycles
module fwd_hazard_ctrl #(
    parameter int XLEN     = 32,
    parameter int NSRC     = 2,
    parameter int NSTAGE   = 3,
    parameter int LOAD_LAT = 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   issue_valid,
    input  logic [4:0]             issue_rd,
    input  logic                   issue_wb,
    input  logic                   issue_is_load,
    input  logic [NSRC*5-1:0]      src_addr,
    input  logic [NSRC-1:0]        src_used,
    input  logic [NSTAGE*XLEN-1:0] stage_result,
    input  logic                   flush,
    output logic                   stall,
    output logic [NSRC-1:0]        fwd_hit,
    output logic [NSRC*XLEN-1:0]   fwd_data,
    output logic [31:0]            stall_cycles
);

    logic [NSTAGE-1:0] valid_q;
    logic [NSTAGE-1:0] wb_q;
    logic [NSTAGE-1:0] ld_q;
    logic [4:0]        rd_q [NSTAGE];

    logic [NSRC-1:0]   hazard;
    logic              found;
    logic              capture_d;
    logic [31:0]       stall_cnt_q;
    logic [31:0]       stall_cnt_d;

    // Scan from the youngest entry outward; the first tag match decides the
    // operand, so an older ready producer can never mask a younger load.
    always_comb begin
        fwd_hit  = '0;
        fwd_data = '0;
        hazard   = '0;
        found    = 1'b0;
        for (int j = 0; j < NSRC; j++) begin
            found = 1'b0;
            if (src_used[j] && (src_addr[j*5 +: 5] != 5'd0)) begin
                for (int i = 0; i < NSTAGE; i++) begin
                    if (!found && valid_q[i] && wb_q[i] &&
                        (rd_q[i] == src_addr[j*5 +: 5])) begin
                        found = 1'b1;
                        if (!ld_q[i] || (i >= LOAD_LAT)) begin
                            fwd_hit[j]               = 1'b1;
                            fwd_data[j*XLEN +: XLEN] = stage_result[i*XLEN +: XLEN];
                        end else begin
                            hazard[j] = 1'b1;
                        end
                    end
                end
            end
        end
    end

    assign stall        = issue_valid & ~flush & (|hazard);
    assign capture_d    = issue_valid & ~stall & ~flush;
    assign stall_cnt_d  = (stall && (stall_cnt_q != 32'hFFFF_FFFF)) ? stall_cnt_q + 32'd1
                                                                   : stall_cnt_q;
    assign stall_cycles = stall_cnt_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q     <= '0;
            wb_q        <= '0;
            ld_q        <= '0;
            stall_cnt_q <= '0;
            for (int i = 0; i < NSTAGE; i++) begin
                rd_q[i] <= 5'd0;
            end
        end else begin
            stall_cnt_q <= stall_cnt_d;
            for (int i = 1; i < NSTAGE; i++) begin
                valid_q[i] <= valid_q[i-1];
                wb_q[i]    <= wb_q[i-1];
                ld_q[i]    <= ld_q[i-1];
                rd_q[i]    <= rd_q[i-1];
            end
            // A redirect kills the stage-0 entry before it moves on.
            valid_q[1] <= valid_q[0] & ~flush;
            valid_q[0] <= capture_d;
            wb_q[0]    <= capture_d & issue_wb & (issue_rd != 5'd0);
            ld_q[0]    <= capture_d & issue_is_load;
            rd_q[0]    <= capture_d ? issue_rd : 5'd0;
        end
    end

endmodule

// File: tb/tb_fwd_hazard_ctrl.sv
module tb_fwd_hazard_ctrl;

    localparam int XLEN     = 32;
    localparam int NSRC     = 2;
    localparam int NSTAGE   = 3;
    localparam int LOAD_LAT = 1;

    logic                   clk = 1'b0;
    logic                   rst = 1'b1;
    logic                   issue_valid = 1'b0;
    logic [4:0]             issue_rd = '0;
    logic                   issue_wb = 1'b0;
    logic                   issue_is_load = 1'b0;
    logic [NSRC*5-1:0]      src_addr = '0;
    logic [NSRC-1:0]        src_used = '0;
    logic [NSTAGE*XLEN-1:0] stage_result = '0;
    logic                   flush = 1'b0;
    logic                   stall;
    logic [NSRC-1:0]        fwd_hit;
    logic [NSRC*XLEN-1:0]   fwd_data;
    logic [31:0]            stall_cycles;

    fwd_hazard_ctrl #(.XLEN(XLEN), .NSRC(NSRC), .NSTAGE(NSTAGE), .LOAD_LAT(LOAD_LAT)) dut (
        .clk(clk), .rst(rst),
        .issue_valid(issue_valid), .issue_rd(issue_rd), .issue_wb(issue_wb),
        .issue_is_load(issue_is_load), .src_addr(src_addr), .src_used(src_used),
        .stage_result(stage_result), .flush(flush),
        .stall(stall), .fwd_hit(fwd_hit), .fwd_data(fwd_data), .stall_cycles(stall_cycles)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit       v;
        bit [4:0] rd;
        bit       wb;
        bit       ld;
    } ent_t;

    ent_t        inflight [NSTAGE];   // index 0 = youngest (EX)
    longint      m_cnt;
    bit          exp_stall;
    bit [NSRC-1:0]        exp_hit;
    bit [NSRC*XLEN-1:0]   exp_data;
    int          total  = 0;
    int          passed = 0;

    task automatic chk(input string tag, input logic [95:0] obs, input logic [95:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic model_clear();
        for (int i = 0; i < NSTAGE; i++) inflight[i] = '{0, 0, 0, 0};
        m_cnt = 0;
    endtask

    // Expected outputs from the current in-flight list and decode inputs.
    task automatic model_eval();
        bit any_haz;
        any_haz  = 0;
        exp_hit  = '0;
        exp_data = '0;
        for (int j = 0; j < NSRC; j++) begin
            int reg_no;
            int producer;
            reg_no   = int'(src_addr[j*5 +: 5]);
            producer = -1;
            if (src_used[j] && reg_no != 0) begin
                for (int i = NSTAGE - 1; i >= 0; i--)
                    if (inflight[i].v && inflight[i].wb && int'(inflight[i].rd) == reg_no)
                        producer = i;   // ends on the youngest producer
            end
            if (producer >= 0) begin
                if (!inflight[producer].ld || producer >= LOAD_LAT) begin
                    exp_hit[j] = 1;
                    exp_data[j*XLEN +: XLEN] = stage_result[producer*XLEN +: XLEN];
                end else begin
                    any_haz = 1;
                end
            end
        end
        exp_stall = issue_valid && !flush && any_haz;
    endtask

    task automatic check_model(input string tag);
        model_eval();
        chk({tag, ".stall"}, 96'(stall), 96'(exp_stall));
        chk({tag, ".fwd_hit"}, 96'(fwd_hit), 96'(exp_hit));
        chk({tag, ".fwd_data"}, 96'(fwd_data), 96'(exp_data));
        chk({tag, ".stall_cycles"}, 96'(stall_cycles), 96'(m_cnt));
    endtask

    // Clock edge: advance the in-flight list the same way the pipeline moves.
    task automatic tick();
        bit cap;
        model_eval();
        cap = issue_valid && !exp_stall && !flush;
        @(posedge clk);
        if (exp_stall && m_cnt < 64'hFFFF_FFFF) m_cnt++;
        if (flush) inflight[0].v = 0;
        for (int i = NSTAGE - 1; i > 0; i--) inflight[i] = inflight[i-1];
        if (cap) inflight[0] = '{1, issue_rd, issue_wb && issue_rd != 0, issue_is_load};
        else     inflight[0] = '{0, 0, 0, 0};
        #1;
    endtask

    task automatic drive(input logic v, input logic [4:0] rd, input logic wb, input logic ld,
                         input logic [4:0] s1, input logic [4:0] s0, input logic [1:0] su,
                         input logic fl, input logic [95:0] sr);
        issue_valid = v; issue_rd = rd; issue_wb = wb; issue_is_load = ld;
        src_addr = {s1, s0}; src_used = su; flush = fl; stage_result = sr;
    endtask

    task automatic step(input string tag, input logic v, input logic [4:0] rd, input logic wb,
                        input logic ld, input logic [4:0] s1, input logic [4:0] s0,
                        input logic [1:0] su, input logic fl, input logic [95:0] sr);
        drive(v, rd, wb, ld, s1, s0, su, fl, sr);
        @(negedge clk);
        check_model(tag);
        tick();
    endtask

    initial begin
        logic [31:0] cnt_before;
        model_clear();
        #12;
        chk("reset.stall", 96'(stall), 96'(0));
        chk("reset.fwd_hit", 96'(fwd_hit), 96'(0));
        chk("reset.fwd_data", 96'(fwd_data), 96'(0));
        chk("reset.stall_cycles", 96'(stall_cycles), 96'(0));
        @(negedge clk); rst = 1'b0;
        @(posedge clk); #1;

        // Forward from EX
        step("t1.issue", 1, 5'd5, 1, 0, 5'd0, 5'd0, 2'b00, 0, '0);
        drive(1, 5'd9, 1, 0, 5'd0, 5'd5, 2'b01, 0, {32'h0, 32'h0, 32'h0000_1234});
        @(negedge clk);
        check_model("t1.use");
        chk("t1.hit0", 96'(fwd_hit[0]), 96'(1));
        chk("t1.data0", 96'(fwd_data[31:0]), 96'(32'h0000_1234));
        tick();

        // Youngest wins
        step("t2.w_old", 1, 5'd5, 1, 0, 5'd0, 5'd0, 2'b00, 0, '0);
        step("t2.w_new", 1, 5'd5, 1, 0, 5'd0, 5'd0, 2'b00, 0, '0);
        drive(1, 5'd10, 1, 0, 5'd5, 5'd0, 2'b10, 0, {32'h0, 32'hBBBB_BBBB, 32'hAAAA_AAAA});
        @(negedge clk);
        check_model("t2.use");
        chk("t2.data1", 96'(fwd_data[63:32]), 96'(32'hAAAA_AAAA));
        tick();
        step("t2.drain", 0, 5'd0, 0, 0, 5'd0, 5'd0, 2'b00, 0, '0);
        step("t2.drain2", 0, 5'd0, 0, 0, 5'd0, 5'd0, 2'b00, 0, '0);

        // Load-use
        step("t3.lw", 1, 5'd7, 1, 1, 5'd0, 5'd0, 2'b00, 0, '0);
        drive(1, 5'd11, 1, 0, 5'd0, 5'd7, 2'b01, 0, '0);
        @(negedge clk);
        check_model("t3.stall");
        chk("t3.stall_hi", 96'(stall), 96'(1));
        tick();
        drive(1, 5'd11, 1, 0, 5'd0, 5'd7, 2'b01, 0, {32'h0, 32'hDEAD_BEEF, 32'h0});
        @(negedge clk);
        check_model("t3.after");
        chk("t3.stall_lo", 96'(stall), 96'(0));
        chk("t3.hit0", 96'(fwd_hit[0]), 96'(1));
        chk("t3.data0", 96'(fwd_data[31:0]), 96'(32'hDEAD_BEEF));
        chk("t3.cnt", 96'(stall_cycles), 96'(1));
        tick();

        // x0 and unused operands
        step("t4.w6", 1, 5'd6, 1, 0, 5'd0, 5'd0, 2'b00, 0, '0);
        step("t4.w0", 1, 5'd0, 1, 0, 5'd0, 5'd0, 2'b00, 0, '0);
        drive(1, 5'd12, 1, 0, 5'd6, 5'd0, 2'b01, 0, {32'h3, 32'h2, 32'h1});
        @(negedge clk);
        check_model("t4.use");
        chk("t4.hit", 96'(fwd_hit), 96'(0));
        chk("t4.stall", 96'(stall), 96'(0));
        tick();

        // Flush over hazard
        step("t5.lw", 1, 5'd7, 1, 1, 5'd0, 5'd0, 2'b00, 0, '0);
        cnt_before = stall_cycles;
        drive(1, 5'd8, 1, 0, 5'd0, 5'd7, 2'b01, 1, '0);
        @(negedge clk);
        check_model("t5.flush");
        chk("t5.stall", 96'(stall), 96'(0));
        tick();
        drive(1, 5'd13, 1, 0, 5'd8, 5'd7, 2'b11, 0, {32'h5, 32'h4, 32'h3});
        @(negedge clk);
        check_model("t5.after");
        chk("t5.no_hit", 96'(fwd_hit), 96'(0));
        chk("t5.cnt", 96'(stall_cycles), 96'(cnt_before));
        tick();

        // Randomized traffic against the model
        for (int n = 0; n < 400; n++) begin
            step("rand", 1'($urandom_range(0, 3) != 0), 5'($urandom_range(0, 7)),
                 1'($urandom), 1'($urandom), 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                 2'($urandom), 1'($urandom_range(0, 9) == 0),
                 {$urandom, $urandom, $urandom});
        end

        // Async reset while stalled
        step("t6.lw", 1, 5'd7, 1, 1, 5'd0, 5'd0, 2'b00, 0, '0);
        drive(1, 5'd14, 1, 0, 5'd0, 5'd7, 2'b01, 0, '0);
        #1;
        chk("t6.pre_stall", 96'(stall), 96'(1));
        rst = 1'b1;
        #1;
        chk("t6.stall", 96'(stall), 96'(0));
        chk("t6.cnt", 96'(stall_cycles), 96'(0));
        model_clear();
        @(negedge clk); rst = 1'b0;
        @(posedge clk); #1;
        drive(1, 5'd14, 1, 0, 5'd0, 5'd7, 2'b01, 0, {32'h9, 32'h8, 32'h7});
        @(negedge clk);
        check_model("t6.reissue");
        chk("t6.no_hit", 96'(fwd_hit), 96'(0));
        tick();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
